// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: fetch-unit bus bundle (redirect/stall control, imem port, decode handshake).
// The master modport is the fetch unit; the slave modport is the surrounding pipeline/memory.
interface pc_fetch_unit_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               stall;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [ADDR_W-1:0]  out_pc;
    logic [ADDR_W-1:0]  out_pcp1;
    logic [INSTR_W-1:0] out_instr;
    modport master (
        input  redirect_valid, redirect_pc, stall, imem_rdata, out_ready,
        output imem_req, imem_addr, out_valid, out_pc, out_pcp1, out_instr
    );
    modport slave (
        output redirect_valid, redirect_pc, stall, imem_rdata, out_ready,
        input  imem_req, imem_addr, out_valid, out_pc, out_pcp1, out_instr
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: PC register, 1-cycle imem fetch, 2-entry output FIFO with branch redirect/flush.
// Defining FETCH_PERF_EN adds the perf_fetch_cnt / perf_flush_cnt counters.
module pc_fetch_unit #(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef FETCH_PERF_EN
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_flush_cnt,
`endif
    pc_fetch_unit_if.master bus
);
    typedef enum logic {IDLE, RUN} state_t;
    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d, tag_q, tag_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         count_q, count_d;
    logic               rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0]  fpc_q [2];
    logic [INSTR_W-1:0] fins_q [2];
    logic               pop, push, req;
    always_comb begin
        pop        = (count_q != 2'd0) && bus.out_ready;
        push       = inflight_q && !bus.redirect_valid;
        // every outstanding request owns a FIFO slot, so a landing response always fits
        req        = (state_q == RUN) && !bus.stall && !bus.redirect_valid &&
                     (((count_q + {1'b0, inflight_q}) < 2'd2) || pop);
        state_d    = RUN;
        pc_d       = bus.redirect_valid ? bus.redirect_pc : req ? pc_q + ADDR_W'(1) : pc_q;
        tag_d      = req ? pc_q : tag_q;
        inflight_d = req;
        count_d    = bus.redirect_valid ? 2'd0 : count_q + {1'b0, push} - {1'b0, pop};
        rd_d       = bus.redirect_valid ? 1'b0 : rd_q ^ pop;
        wr_d       = bus.redirect_valid ? 1'b0 : wr_q ^ push;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            tag_q      <= '0;
            inflight_q <= 1'b0;
            count_q    <= 2'd0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            fpc_q      <= '{default: '0};
            fins_q     <= '{default: '0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            tag_q      <= tag_d;
            inflight_q <= inflight_d;
            count_q    <= count_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            if (push) begin
                fpc_q[wr_q]  <= tag_q;
                fins_q[wr_q] <= bus.imem_rdata;
            end
        end
    end
    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = count_q != 2'd0;
    assign bus.out_pc    = fpc_q[rd_q];
    assign bus.out_pcp1  = fpc_q[rd_q] + ADDR_W'(1);
    assign bus.out_instr = fins_q[rd_q];
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d, flush_cnt_q, flush_cnt_d;
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + 32'(pop);
        flush_cnt_d = flush_cnt_q + 32'(bus.redirect_valid);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end
    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_flush_cnt = flush_cnt_q;
`endif
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: vector table, hand sequences and random stimulus against an instruction-stream model.
// A second instance with RESET_PC=0xFFFFFFFE covers the PC wrap.
module tb_pc_fetch_unit;
    localparam logic [31:0] KEY = 32'hA5A5A5A5;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic first_done = 1'b0;
    int   errors = 0;
    int   checks = 0;
    always #5 clk = ~clk;

    pc_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) b0 ();
    pc_fetch_unit_if #(.ADDR_W(32), .INSTR_W(32)) b1 ();
`ifdef FETCH_PERF_EN
    logic [31:0] pf0, pl0, pf1, pl1;
`endif
    pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'h0)) dut0 (
        .clk(clk), .rst_n(rst_n),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(pf0), .perf_flush_cnt(pl0),
`endif
        .bus(b0));
    pc_fetch_unit #(.ADDR_W(32), .INSTR_W(32), .RESET_PC(32'hFFFF_FFFE)) dut1 (
        .clk(clk), .rst_n(rst_n),
`ifdef FETCH_PERF_EN
        .perf_fetch_cnt(pf1), .perf_flush_cnt(pl1),
`endif
        .bus(b1));

    // 1-cycle synchronous instruction memory: instr = addr ^ KEY
    always @(posedge clk) begin
        b0.imem_rdata <= b0.imem_req ? (b0.imem_addr ^ KEY) : 32'h0;
        b1.imem_rdata <= b1.imem_req ? (b1.imem_addr ^ KEY) : 32'h0;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Stream model: decode must see consecutive PCs from the last reset/redirect target.
    logic [31:0] next_pc;
    int          held, starve, n_pop, n_flush;
    logic        hold_v;
    logic [31:0] hold_pc, hold_ins;

    task automatic model_reset();
        next_pc = 32'h0; held = 0; starve = 0; n_pop = 0; n_flush = 0; hold_v = 1'b0;
    endtask

    task automatic sample();
        @(negedge clk);
`ifdef FETCH_PERF_EN
        chk("perf_fetch", pf0, n_pop);
        chk("perf_flush", pl0, n_flush);
`endif
        if (hold_v) begin
            chk("hold_valid", 32'(b0.out_valid), 32'd1);
            chk("hold_pc", b0.out_pc, hold_pc);
            chk("hold_instr", b0.out_instr, hold_ins);
        end
        hold_v = b0.out_valid && !b0.out_ready && !b0.redirect_valid;
        hold_pc = b0.out_pc;
        hold_ins = b0.out_instr;
        if (b0.out_valid && b0.out_ready) begin
            chk("stream_pc", b0.out_pc, next_pc);
            chk("stream_pcp1", b0.out_pcp1, next_pc + 32'd1);
            chk("stream_instr", b0.out_instr, next_pc ^ KEY);
            next_pc++;
            n_pop++;
        end
        if (b0.redirect_valid) begin
            next_pc = b0.redirect_pc;
            held = 0;
            n_flush++;
        end else begin
            held += int'(b0.imem_req) - int'(b0.out_valid && b0.out_ready);
        end
        checks++;
        if (held < 0 || held > 2) begin
            errors++;
            $display("FAIL held: got %0d expected 0..2 at %0t", held, $time);
        end
        starve = (b0.out_valid || b0.stall || b0.redirect_valid) ? 0 : starve + 1;
        checks++;
        if (starve > 3) begin
            errors++;
            $display("FAIL starve: got %0d idle cycles expected <=3 at %0t", starve, $time);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ready, input logic stall, input logic rv, input logic [31:0] rpc);
        b0.out_ready = ready; b0.stall = stall; b0.redirect_valid = rv; b0.redirect_pc = rpc;
    endtask

    // Asserts reset mid-cycle, checks reset values at once, releases before edge 0; returns in cycle 1.
    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        #1;
        chk("rst_req", 32'(b0.imem_req), 32'd0);
        chk("rst_addr", b0.imem_addr, 32'h0);
        chk("rst_valid", 32'(b0.out_valid), 32'd0);
        chk("rst_pc", b0.out_pc, 32'h0);
        chk("rst_pcp1", b0.out_pcp1, 32'h1);
        chk("rst_instr", b0.out_instr, 32'h0);
        chk("rst1_addr", b1.imem_addr, 32'hFFFF_FFFE);
        chk("rst1_pcp1", b1.out_pcp1, 32'h1);
`ifdef FETCH_PERF_EN
        chk("rst_perf_fetch", pf0, 32'h0);
        chk("rst_perf_flush", pl0, 32'h0);
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_reset();
        advance();
    endtask

    typedef struct {
        logic        ready, stall, rv;
        logic [31:0] rpc;
        logic        ereq;
        logic [31:0] eaddr;
        logic        evalid;
        logic [31:0] epc;
    } vec_t;
    vec_t vec [29];

    function automatic vec_t v(input logic ready, input logic stall, input logic rv, input logic [31:0] rpc,
                               input logic ereq, input logic [31:0] eaddr, input logic evalid,
                               input logic [31:0] epc);
        vec_t r;
        r.ready = ready; r.stall = stall; r.rv = rv; r.rpc = rpc;
        r.ereq = ereq; r.eaddr = eaddr; r.evalid = evalid; r.epc = epc;
        return r;
    endfunction

    task automatic run_vec(input int first, input int last);
        for (int i = first; i <= last; i++) begin
            drive(vec[i].ready, vec[i].stall, vec[i].rv, vec[i].rpc);
            sample();
            chk($sformatf("c%0d_req", i + 1), 32'(b0.imem_req), 32'(vec[i].ereq));
            chk($sformatf("c%0d_addr", i + 1), b0.imem_addr, vec[i].eaddr);
            chk($sformatf("c%0d_valid", i + 1), 32'(b0.out_valid), 32'(vec[i].evalid));
            if (vec[i].evalid) chk($sformatf("c%0d_pc", i + 1), b0.out_pc, vec[i].epc);
            advance();
        end
    endtask

    // Wrap instance: cold start delivers FFFFFFFE, FFFFFFFF, 0, 1 from cycle 3.
    initial begin
        logic [31:0] exp;
        b1.redirect_valid = 1'b0; b1.redirect_pc = 32'h0; b1.stall = 1'b0; b1.out_ready = 1'b1;
        wait (first_done);
        exp = 32'hFFFF_FFFE;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("wrap_c%0d_valid", c), 32'(b1.out_valid), 32'(c >= 3));
            if (c >= 3) begin
                chk("wrap_pc", b1.out_pc, exp);
                chk("wrap_pcp1", b1.out_pcp1, exp + 32'd1);
                exp++;
            end
        end
    end

    initial begin
        // cold start, stall drain, 5-cycle back-pressure, redirect with inflight, redirect with full FIFO
        vec[0]  = v(1, 0, 0, 32'h0,   1, 32'd0,   0, 32'h0);
        vec[1]  = v(1, 0, 0, 32'h0,   1, 32'd1,   0, 32'h0);
        vec[2]  = v(1, 0, 0, 32'h0,   1, 32'd2,   1, 32'd0);
        vec[3]  = v(1, 0, 0, 32'h0,   1, 32'd3,   1, 32'd1);
        vec[4]  = v(1, 0, 0, 32'h0,   1, 32'd4,   1, 32'd2);
        vec[5]  = v(1, 1, 0, 32'h0,   0, 32'd5,   1, 32'd3);
        vec[6]  = v(1, 1, 0, 32'h0,   0, 32'd5,   1, 32'd4);
        vec[7]  = v(1, 1, 0, 32'h0,   0, 32'd5,   0, 32'h0);
        vec[8]  = v(1, 1, 0, 32'h0,   0, 32'd5,   0, 32'h0);
        vec[9]  = v(1, 0, 0, 32'h0,   1, 32'd5,   0, 32'h0);
        vec[10] = v(1, 0, 0, 32'h0,   1, 32'd6,   0, 32'h0);
        vec[11] = v(1, 0, 0, 32'h0,   1, 32'd7,   1, 32'd5);
        vec[12] = v(0, 0, 0, 32'h0,   0, 32'd8,   1, 32'd6);
        vec[13] = v(0, 0, 0, 32'h0,   0, 32'd8,   1, 32'd6);
        vec[14] = v(0, 0, 0, 32'h0,   0, 32'd8,   1, 32'd6);
        vec[15] = v(0, 0, 0, 32'h0,   0, 32'd8,   1, 32'd6);
        vec[16] = v(0, 0, 0, 32'h0,   0, 32'd8,   1, 32'd6);
        vec[17] = v(1, 0, 0, 32'h0,   1, 32'd8,   1, 32'd6);
        vec[18] = v(1, 0, 0, 32'h0,   1, 32'd9,   1, 32'd7);
        vec[19] = v(1, 0, 1, 32'h100, 0, 32'd10,  1, 32'd8);
        vec[20] = v(1, 0, 0, 32'h0,   1, 32'h100, 0, 32'h0);
        vec[21] = v(1, 0, 0, 32'h0,   1, 32'h101, 0, 32'h0);
        vec[22] = v(1, 0, 0, 32'h0,   1, 32'h102, 1, 32'h100);
        vec[23] = v(1, 0, 0, 32'h0,   1, 32'h103, 1, 32'h101);
        vec[24] = v(0, 0, 0, 32'h0,   0, 32'h104, 1, 32'h102);
        vec[25] = v(0, 0, 1, 32'h200, 0, 32'h104, 1, 32'h102);
        vec[26] = v(1, 0, 0, 32'h0,   1, 32'h200, 0, 32'h0);
        vec[27] = v(1, 0, 0, 32'h0,   1, 32'h201, 0, 32'h0);
        vec[28] = v(1, 0, 0, 32'h0,   1, 32'h202, 1, 32'h200);
        model_reset();
        #1;
        do_reset();
        first_done = 1'b1;
        run_vec(0, 28);
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(9) < 7, $urandom_range(7) == 0, $urandom_range(19) == 0, $urandom);
            sample();
            advance();
        end
        drive(1'b1, 1'b0, 1'b0, 32'h0);
        for (int n = 0; n < 6; n++) begin
            sample();
            advance();
        end
        do_reset();
        run_vec(0, 4);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
